// File: rtl/fifo_sync_param.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_sync_param
//  Purpose  : Parametrised single-clock circular-buffer FIFO with programmable
//             almost-full/almost-empty flags and sticky overflow/underflow.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_sync_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32,
  parameter int AF_LEVEL   = 28,
  parameter int AE_LEVEL   = 4
) (
  input  logic                  CLOCK,
  input  logic                  RESET_N,
  input  logic                  CLEAR_N,
  input  logic                  WRITE,
  input  logic                  READ,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  F_FULL_N,
  output logic                  F_EMPTY_N,
  output logic                  F_AFULL_N,
  output logic                  F_AEMPTY_N,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW,
  output logic [$clog2(DEPTH):0] USE_DW
);

  localparam int AW = $clog2(DEPTH);

  // Count-width copies of the integer parameters so comparisons stay width-matched
  localparam logic [AW:0]   CNT_ZERO  = '0;
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AF_CNT    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0]   AE_CNT    = (AW+1)'(AE_LEVEL);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FULL   = 2'd2
  } state_t;

  state_t                state_q;
  logic [AW-1:0]         wptr_q, rptr_q;
  logic [AW-1:0]         wptr_d, rptr_d;
  logic [AW:0]           cnt_q;
  logic [AW:0]           cnt_up_d, cnt_dn_d;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  ovf_q, unf_q;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Pointers wrap DEPTH-1 -> 0 naturally because DEPTH is a power of two
  assign wptr_d   = wptr_q + PTR_ONE;
  assign rptr_d   = rptr_q + PTR_ONE;
  assign cnt_up_d = cnt_q + CNT_ONE;
  assign cnt_dn_d = cnt_q - CNT_ONE;

  // A word is stored unless the FIFO is full without a read, or empty with a
  // simultaneous read (bypass); a flush suppresses all storage
  assign mem_we = CLEAR_N && WRITE &&
                  ((state_q == ST_ACTIVE) ||
                   (state_q == ST_FULL  &&  READ) ||
                   (state_q == ST_EMPTY && !READ));

  // Storage array; contents need no reset since occupancy gates every read
  always_ff @(posedge CLOCK) begin
    if (mem_we) mem_q[wptr_q] <= DATA_IN;
  end

  // Control FSM: pointers, occupancy, read data and sticky error flags
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_EMPTY;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= CNT_ZERO;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (!CLEAR_N) begin
      state_q <= ST_EMPTY;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= CNT_ZERO;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (WRITE && READ) begin
            dout_q <= DATA_IN;
          end else if (WRITE) begin
            wptr_q  <= wptr_d;
            cnt_q   <= CNT_ONE;
            state_q <= ST_ACTIVE;
          end else if (READ) begin
            unf_q <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (WRITE && READ) begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            dout_q <= mem_q[rptr_q];
          end else if (WRITE) begin
            wptr_q <= wptr_d;
            cnt_q  <= cnt_up_d;
            if (cnt_up_d == DEPTH_CNT) state_q <= ST_FULL;
          end else if (READ) begin
            rptr_q <= rptr_d;
            dout_q <= mem_q[rptr_q];
            cnt_q  <= cnt_dn_d;
            if (cnt_dn_d == CNT_ZERO) state_q <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (WRITE && READ) begin
            // Head is read before the write lands in the slot it frees
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            dout_q <= mem_q[rptr_q];
          end else if (WRITE) begin
            ovf_q <= 1'b1;
          end else if (READ) begin
            rptr_q  <= rptr_d;
            dout_q  <= mem_q[rptr_q];
            cnt_q   <= cnt_dn_d;
            state_q <= ST_ACTIVE;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  // Flags decode from registered count, so they only move at clock edges
  assign F_FULL_N   = (cnt_q != DEPTH_CNT);
  assign F_EMPTY_N  = (cnt_q != CNT_ZERO);
  assign F_AFULL_N  = !(cnt_q >= AF_CNT);
  assign F_AEMPTY_N = !(cnt_q <= AE_CNT);
  assign OVERFLOW   = ovf_q;
  assign UNDERFLOW  = unf_q;
  assign USE_DW     = cnt_q;
  assign DATA_OUT   = dout_q;

endmodule
`default_nettype wire
